// File: rtl/oam_dma_arbiter.sv
// Game Boy OAM DMA arbiter: passes SM83 memory traffic through when idle and
// takes over both memory ports to copy DMA_LEN bytes into OAM on a DMA register write.
module oam_dma_arbiter #(
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
    parameter logic [15:0] OAM_BASE     = 16'hFE00,
    parameter int          DMA_LEN      = 160
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_wen,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] mem_r_addr,
    output logic [15:0] mem_w_addr,
    output logic        mem_wen,
    output logic [7:0]  mem_w_data,
    input  logic [7:0]  mem_r_data,
    output logic        dma_active
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_XFER  = 2'd2;

    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

    logic [1:0] state;
    logic [7:0] src_hi;
    logic [7:0] idx;
    logic       trigger;
    logic [7:0] folded_src;

    assign trigger = cpu_wen && (cpu_addr == DMA_REG_ADDR);

    // Echo RAM pages E0-FF mirror C0-DF, so bit 5 is cleared for those sources.
    assign folded_src = (cpu_wdata >= 8'hE0) ? (cpu_wdata & 8'hDF) : cpu_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            src_hi <= 8'h00;
            idx    <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        state  <= S_START;
                        src_hi <= folded_src;
                        idx    <= 8'h00;
                    end
                end
                S_START: begin
                    if (trigger) begin
                        src_hi <= folded_src;
                        idx    <= 8'h00;
                        state  <= S_START;
                    end else begin
                        state <= S_XFER;
                    end
                end
                S_XFER: begin
                    // A restart takes priority over finishing the final byte.
                    if (trigger) begin
                        state  <= S_START;
                        src_hi <= folded_src;
                        idx    <= 8'h00;
                    end else if (idx == LAST_IDX) begin
                        state <= S_IDLE;
                        idx   <= 8'h00;
                    end else begin
                        idx <= idx + 8'h01;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    idx   <= 8'h00;
                end
            endcase
        end
    end

    always_comb begin
        mem_r_addr = cpu_addr;
        mem_w_addr = cpu_addr;
        mem_w_data = cpu_wdata;
        mem_wen    = cpu_wen;
        cpu_rdata  = mem_r_data;
        // Reset gates the outputs directly so nothing is written while rst is held.
        if (rst) begin
            mem_wen   = 1'b0;
            cpu_rdata = 8'hFF;
        end else begin
            case (state)
                S_START: begin
                    mem_r_addr = {src_hi, 8'h00};
                    mem_w_addr = OAM_BASE;
                    mem_wen    = 1'b0;
                    cpu_rdata  = 8'hFF;
                end
                S_XFER: begin
                    mem_r_addr = {src_hi, idx};
                    mem_w_addr = OAM_BASE + {8'h00, idx};
                    mem_w_data = mem_r_data;
                    mem_wen    = 1'b1;
                    cpu_rdata  = 8'hFF;
                end
                default: begin
                end
            endcase
        end
    end

    assign dma_active = (state != S_IDLE);

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench for oam_dma_arbiter: a 64 KiB memory model plus table-driven
// pass-through vectors and hand-written DMA, lockout, restart and reset sequences.
module tb_oam_dma_arbiter;

    logic        clk;
    logic        rst;
    logic [15:0] cpu_addr;
    logic        cpu_wen;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic [15:0] mem_r_addr;
    logic [15:0] mem_w_addr;
    logic        mem_wen;
    logic [7:0]  mem_w_data;
    logic [7:0]  mem_r_data;
    logic        dma_active;

    logic [7:0] mem [0:65535];

    int checks;
    int errors;

    typedef struct {
        logic [15:0] addr;
        logic        wen;
        logic [7:0]  wdata;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs [0:7];

    oam_dma_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_wen    (cpu_wen),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .mem_r_addr (mem_r_addr),
        .mem_w_addr (mem_w_addr),
        .mem_wen    (mem_wen),
        .mem_w_data (mem_w_data),
        .mem_r_data (mem_r_data),
        .dma_active (dma_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_r_data = mem[mem_r_addr];

    always @(posedge clk) begin
        if (mem_wen) mem[mem_w_addr] <= mem_w_data;
    end

    task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Counts OAM bytes in [first,last] that differ from i^key (or from zero when blank is set).
    function automatic int oam_bad(input int first, input int last, input logic [7:0] key, input logic blank);
        int bad;
        logic [7:0] want;
        bad = 0;
        for (int i = first; i <= last; i++) begin
            want = blank ? 8'h00 : (8'(i) ^ key);
            if (mem[16'hFE00 + 16'(i)] !== want) bad++;
        end
        return bad;
    endfunction

    task automatic clear_oam();
        for (int i = 0; i < 160; i++) mem[16'hFE00 + 16'(i)] = 8'h00;
    endtask

    // Triggers a DMA from src_val and counts dma_active cycles, with optional lockout probes and a restart.
    task automatic run_dma(input logic [7:0] src_val, input logic [7:0] exp_src, input logic lockout,
                           input int restart_at, input logic [7:0] restart_val, output int cnt);
        @(negedge clk);
        cpu_addr  = 16'hFF46;
        cpu_wdata = src_val;
        cpu_wen   = 1'b1;
        @(negedge clk);
        cpu_wen  = 1'b0;
        cpu_addr = 16'h0000;
        cnt = 0;
        for (int guard = 0; guard < 600; guard++) begin
            if (!dma_active) break;
            cnt++;
            cpu_wen = 1'b0;
            #1;
            if (cnt == 1) begin
                check_output("start_wen", {15'b0, mem_wen}, 16'h0000);
                check_output("start_rdata", {8'h00, cpu_rdata}, 16'h00FF);
            end
            if (cnt == 2) begin
                check_output("first_wen", {15'b0, mem_wen}, 16'h0001);
                check_output("first_raddr", mem_r_addr, {exp_src, 8'h00});
                check_output("first_waddr", mem_w_addr, 16'hFE00);
            end
            if (restart_at == 0 && cnt == 161)
                check_output("last_waddr", mem_w_addr, 16'hFE9F);
            if (lockout && cnt == 20) begin
                cpu_addr = 16'hC000;
                #1;
                check_output("lockout_read", {8'h00, cpu_rdata}, 16'h00FF);
            end
            if (lockout && cnt == 30) begin
                cpu_addr  = 16'hC100;
                cpu_wdata = 8'h11;
                cpu_wen   = 1'b1;
            end
            if (restart_at != 0 && cnt == restart_at) begin
                cpu_addr  = 16'hFF46;
                cpu_wdata = restart_val;
                cpu_wen   = 1'b1;
            end
            if (restart_at != 0 && cnt == restart_at + 1) begin
                check_output("pre_restart_bytes", 16'(oam_bad(0, 50, 8'h5A, 1'b0)), 16'h0000);
                check_output("pre_restart_untouched", 16'(oam_bad(51, 159, 8'h00, 1'b1)), 16'h0000);
            end
            @(negedge clk);
        end
        cpu_wen  = 1'b0;
        cpu_addr = 16'h0000;
    endtask

    task automatic apply_stimulus(input logic [15:0] addr, input logic wen, input logic [7:0] wdata);
        @(posedge clk);
        #1;
        cpu_addr  = addr;
        cpu_wen   = wen;
        cpu_wdata = wdata;
    endtask

    initial begin
        int cnt;
        checks = 0;
        errors = 0;
        rst       = 1'b1;
        cpu_addr  = 16'h1234;
        cpu_wen   = 1'b1;
        cpu_wdata = 8'h99;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 160; i++) begin
            mem[16'hC000 + 16'(i)] = 8'(i) ^ 8'h5A;
            mem[16'hD000 + 16'(i)] = 8'(i) ^ 8'hA5;
        end
        mem[16'hC100] = 8'h22;
        mem[16'hFEA0] = 8'h77;
        mem[16'h9000] = 8'h10;
        mem[16'h9001] = 8'h21;
        mem[16'h9003] = 8'h43;
        mem[16'hFFFF] = 8'hEE;

        vecs[0] = '{16'h9000, 1'b0, 8'h00, 8'h10};
        vecs[1] = '{16'h9001, 1'b0, 8'h5A, 8'h21};
        vecs[2] = '{16'h9003, 1'b1, 8'h66, 8'h43};
        vecs[3] = '{16'h9003, 1'b0, 8'h00, 8'h66};
        vecs[4] = '{16'hFFFF, 1'b0, 8'h00, 8'hEE};
        vecs[5] = '{16'h8000, 1'b1, 8'hAB, 8'h00};
        vecs[6] = '{16'h8000, 1'b0, 8'h00, 8'hAB};
        vecs[7] = '{16'h9001, 1'b1, 8'h3C, 8'h21};

        #3;
        check_output("rst_wen", {15'b0, mem_wen}, 16'h0000);
        check_output("rst_rdata", {8'h00, cpu_rdata}, 16'h00FF);
        check_output("rst_active", {15'b0, dma_active}, 16'h0000);
        check_output("rst_raddr", mem_r_addr, 16'h1234);
        check_output("rst_waddr", mem_w_addr, 16'h1234);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_output("rst_no_write", {8'h00, mem[16'h1234]}, 16'h0000);
        rst     = 1'b0;
        cpu_wen = 1'b0;

        for (int v = 0; v < 8; v++) begin
            apply_stimulus(vecs[v].addr, vecs[v].wen, vecs[v].wdata);
            @(negedge clk);
            check_output("pt_raddr", mem_r_addr, vecs[v].addr);
            check_output("pt_waddr", mem_w_addr, vecs[v].addr);
            check_output("pt_wen", {15'b0, mem_wen}, {15'b0, vecs[v].wen});
            check_output("pt_wdata", {8'h00, mem_w_data}, {8'h00, vecs[v].wdata});
            check_output("pt_rdata", {8'h00, cpu_rdata}, {8'h00, vecs[v].exp_rdata});
            check_output("pt_active", {15'b0, dma_active}, 16'h0000);
        end
        apply_stimulus(16'h0000, 1'b0, 8'h00);

        $display("[TB] basic copy with lockout");
        run_dma(8'hC0, 8'hC0, 1'b1, 0, 8'h00, cnt);
        check_output("basic_active_cycles", 16'(cnt), 16'd161);
        check_output("basic_oam", 16'(oam_bad(0, 159, 8'h5A, 1'b0)), 16'h0000);
        check_output("basic_fea0", {8'h00, mem[16'hFEA0]}, 16'h0077);
        check_output("dma_reg_readback", {8'h00, mem[16'hFF46]}, 16'h00C0);
        check_output("lockout_dropped", {8'h00, mem[16'hC100]}, 16'h0022);

        apply_stimulus(16'hC100, 1'b1, 8'h11);
        apply_stimulus(16'hC100, 1'b0, 8'h00);
        @(negedge clk);
        check_output("post_dma_write", {8'h00, cpu_rdata}, 16'h0011);

        $display("[TB] source fold");
        for (int i = 0; i < 160; i++) mem[16'hC100 + 16'(i)] = 8'(i) ^ 8'h3C;
        clear_oam();
        run_dma(8'hE1, 8'hC1, 1'b0, 0, 8'h00, cnt);
        check_output("fold_active_cycles", 16'(cnt), 16'd161);
        check_output("fold_oam", 16'(oam_bad(0, 159, 8'h3C, 1'b0)), 16'h0000);

        $display("[TB] restart at idx 50");
        clear_oam();
        run_dma(8'hC0, 8'hC0, 1'b0, 52, 8'hD0, cnt);
        check_output("restart_active_cycles", 16'(cnt), 16'd213);
        check_output("restart_oam", 16'(oam_bad(0, 159, 8'hA5, 1'b0)), 16'h0000);

        $display("[TB] async reset at idx 80");
        clear_oam();
        @(negedge clk);
        cpu_addr  = 16'hFF46;
        cpu_wdata = 8'hC0;
        cpu_wen   = 1'b1;
        @(negedge clk);
        cpu_wen  = 1'b0;
        cpu_addr = 16'h0000;
        cnt = 0;
        for (int guard = 0; guard < 300; guard++) begin
            if (!dma_active || cnt == 82) break;
            cnt++;
            if (cnt < 82) @(negedge clk);
        end
        check_output("abort_reached", 16'(cnt), 16'd82);
        check_output("abort_wen_before", {15'b0, mem_wen}, 16'h0001);
        #1;
        rst = 1'b1;
        #1;
        check_output("abort_wen", {15'b0, mem_wen}, 16'h0000);
        check_output("abort_active", {15'b0, dma_active}, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_output("abort_written", 16'(oam_bad(0, 79, 8'h5A, 1'b0)), 16'h0000);
        check_output("abort_untouched", 16'(oam_bad(80, 159, 8'h00, 1'b1)), 16'h0000);

        apply_stimulus(16'h8001, 1'b1, 8'h5C);
        @(negedge clk);
        check_output("after_rst_wen", {15'b0, mem_wen}, 16'h0001);
        apply_stimulus(16'h8001, 1'b0, 8'h00);
        @(negedge clk);
        check_output("after_rst_read", {8'h00, cpu_rdata}, 16'h005C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
